// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand widths and the iteration-counter width helper.
package divider_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_M = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must be able to hold N itself, hence N+1 distinct values.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between a producer/consumer (master)
// and the divider (slave).
interface seq_divider_if
    import divider_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [M-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         div_zero;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, q, r, div_zero
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, q, r, div_zero
    );

endinterface

// File: rtl/prefix_sub.sv
// W-bit subtractor a - b = a + ~b + 1 built on a Kogge-Stone prefix carry
// network; the carry-in is folded into bit 0 so resolved spans need grey cells only.
module prefix_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    localparam int L = (W > 1) ? $clog2(W) : 1;

    function automatic logic [1:0] black_cell(input logic g_hi, input logic p_hi,
                                              input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

    function automatic logic grey_cell(input logic g_hi, input logic p_hi, input logic g_lo);
        return g_hi | (p_hi & g_lo);
    endfunction

    logic [W-1:0] nb_s;
    logic [W-1:0] g0_s;
    logic [W-1:0] p0_s;
    logic [W-1:0] carry_s;
    logic [W-1:0] g_lvl_s [0:L];
    logic [W-1:0] p_lvl_s [0:L];

    // Prefix tree: level k combines each span with the one 2^k bits below it.
    always_comb begin
        nb_s = ~b;
        p0_s = a ^ nb_s;
        g0_s = a & nb_s;
        for (int k = 0; k <= L; k++) begin
            g_lvl_s[k] = '0;
            p_lvl_s[k] = '0;
        end
        g_lvl_s[0]    = g0_s;
        g_lvl_s[0][0] = g0_s[0] | p0_s[0];
        p_lvl_s[0]    = p0_s;
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << k)) begin
                    if (i < (2 << k)) begin
                        g_lvl_s[k+1][i] = grey_cell(g_lvl_s[k][i], p_lvl_s[k][i],
                                                    g_lvl_s[k][i-(1<<k)]);
                        p_lvl_s[k+1][i] = 1'b0;
                    end else begin
                        {g_lvl_s[k+1][i], p_lvl_s[k+1][i]} =
                            black_cell(g_lvl_s[k][i], p_lvl_s[k][i],
                                       g_lvl_s[k][i-(1<<k)], p_lvl_s[k][i-(1<<k)]);
                    end
                end else begin
                    g_lvl_s[k+1][i] = g_lvl_s[k][i];
                    p_lvl_s[k+1][i] = p_lvl_s[k][i];
                end
            end
        end
        carry_s   = g_lvl_s[L];
        diff      = p0_s ^ {carry_s[W-2:0], 1'b1};
        no_borrow = carry_s[W-1];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with a
// valid/ready handshake on both operands and result; divide-by-zero short-cuts to DONE.
module seq_divider
    import divider_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int             CW        = cnt_width(N);
    localparam logic [CW-1:0]  LAST_ITER = CW'(N - 1);

    state_e        state_q;
    logic [N-1:0]  dvd_q;
    logic [M-1:0]  rem_q;
    logic [M-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          div_zero_q;
    logic [N-1:0]  q_q;
    logic [M-1:0]  r_q;

    logic [M:0]    partial_s;
    logic [M:0]    trial_s;
    logic          no_borrow_s;
    logic [M-1:0]  rem_d;
    logic [N-1:0]  dvd_d;
    logic          unused_s;

    // Dividend register doubles as quotient register: bits shift out the top, quotient bits enter below.
    assign partial_s = {rem_q, dvd_q[N-1]};
    assign unused_s  = trial_s[M];

    prefix_sub #(.W(M + 1)) u_sub (
        .a         (partial_s),
        .b         ({1'b0, dvs_q}),
        .diff      (trial_s),
        .no_borrow (no_borrow_s)
    );

    // Restoring step: keep the trial remainder only when it did not borrow.
    always_comb begin
        dvd_d = {dvd_q[N-2:0], no_borrow_s};
        if (no_borrow_s) begin
            rem_d = trial_s[M-1:0];
        end else begin
            rem_d = partial_s[M-1:0];
        end
    end

    // Control FSM, iteration datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        dvd_q      <= bus.x;
                        dvs_q      <= bus.y;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        if (bus.y == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            div_zero_q  <= 1'b1;
                            q_q         <= '1;
                            r_q         <= bus.x[M-1:0];
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        div_zero_q  <= 1'b0;
                        q_q         <= dvd_d;
                        r_q         <= rem_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.q         = q_q;
    assign bus.r         = r_q;
    assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, backpressure and
// mid-operation reset sequences, then an exhaustive operand sweep under random backpressure.
module tb_seq_divider;

    localparam int N = 8;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_divider_if #(.N(N), .M(M)) bus ();

    seq_divider #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int x; int y; int q; int r; int dz; } sb_t;
    typedef struct { int x; int y; int q; int r; int dz; int lat; } vec_t;

    sb_t sb[$];
    int  n_cmp    = 0;
    int  n_fail   = 0;
    int  rdy_mode = 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // out_ready driver: 0 = hold low, 1 = hold high, other = random backpressure.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Result monitor: every handshaken result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("result_has_request", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                sb_t e;
                e = sb.pop_front();
                check($sformatf("q x=%0d y=%0d", e.x, e.y), int'(bus.q), e.q);
                check($sformatf("r x=%0d y=%0d", e.x, e.y), int'(bus.r), e.r);
                check($sformatf("div_zero x=%0d y=%0d", e.x, e.y), int'(bus.div_zero), e.dz);
                if (e.y != 0) begin
                    check($sformatf("identity x=%0d y=%0d", e.x, e.y),
                          int'((int'(bus.q) * e.y + int'(bus.r) == e.x) && (int'(bus.r) < e.y)), 1);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input int x, input int y, input int eq, input int er, input int edz);
        int tmo;
        tmo = 0;
        while (!bus.in_ready && tmo < 300) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        if (!bus.in_ready) begin
            check("in_ready_wait", int'(bus.in_ready), 1);
        end else begin
            bus.in_valid = 1'b1;
            bus.x        = N'(x);
            bus.y        = M'(y);
            @(posedge clk);
            sb.push_back('{x, y, eq, er, edz});
            #1;
            bus.in_valid = 1'b0;
            bus.x        = N'($urandom);
            bus.y        = M'($urandom);
        end
    endtask

    // lat counts edges from the accept edge (=1) to the edge that raised out_valid.
    task automatic wait_done(output int lat, output int busy_ok);
        lat     = 1;
        busy_ok = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 60) begin
            if (bus.in_ready) busy_ok = 0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus.in_ready) busy_ok = 0;
    endtask

    initial begin
        vec_t vt [9];
        int   lat;
        int   ok;
        int   q0, r0, dz0, stable, t;

        vt[0] = '{200,  7,  28, 4, 0, 9};
        vt[1] = '{255, 15,  17, 0, 0, 9};
        vt[2] = '{  0,  5,   0, 0, 0, 9};
        vt[3] = '{  3,  9,   0, 3, 0, 9};
        vt[4] = '{100,  0, 255, 4, 1, 1};
        vt[5] = '{ 81,  9,   9, 0, 0, 9};
        vt[6] = '{255,  1, 255, 0, 0, 9};
        vt[7] = '{  1, 15,   0, 1, 0, 9};
        vt[8] = '{  0,  0, 255, 0, 1, 1};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst in_ready",  int'(bus.in_ready),  1);
        check("rst out_valid", int'(bus.out_valid), 0);
        check("rst q",         int'(bus.q),         0);
        check("rst r",         int'(bus.r),         0);
        check("rst div_zero",  int'(bus.div_zero),  0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rdy_mode = 1;
        for (int i = 0; i < 9; i++) begin
            send(vt[i].x, vt[i].y, vt[i].q, vt[i].r, vt[i].dz);
            wait_done(lat, ok);
            check($sformatf("latency x=%0d y=%0d", vt[i].x, vt[i].y), lat, vt[i].lat);
            check($sformatf("in_ready low while pending x=%0d y=%0d", vt[i].x, vt[i].y), ok, 1);
            @(posedge clk);
            #1;
            check("idle in_ready after handshake", int'(bus.in_ready), 1);
            check("out_valid low after handshake", int'(bus.out_valid), 0);
        end

        // Backpressure: result held in DONE while out_ready stays low, operands ignored.
        rdy_mode = 0;
        send(200, 7, 28, 4, 0);
        wait_done(lat, ok);
        check("bp latency", lat, 9);
        q0     = int'(bus.q);
        r0     = int'(bus.r);
        dz0    = int'(bus.div_zero);
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.x        = N'($urandom);
            bus.y        = M'($urandom);
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || int'(bus.q) != q0 ||
                int'(bus.r) != r0 || int'(bus.div_zero) != dz0) stable = 0;
        end
        check("bp outputs stable in DONE", stable, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rdy_mode     = 1;
        @(negedge clk);
        check("bp out_valid before release edge", int'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        check("bp out_valid after release edge", int'(bus.out_valid), 0);
        check("bp in_ready after release edge",  int'(bus.in_ready),  1);

        // Reset at iteration 4 aborts; accept on the first edge after release.
        send(200, 7, 28, 4, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-reset out_valid", int'(bus.out_valid), 0);
        check("mid-reset in_ready",  int'(bus.in_ready),  1);
        sb.delete();
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.x        = N'(81);
        bus.y        = M'(9);
        @(posedge clk);
        sb.push_back('{81, 9, 9, 0, 0});
        #1;
        bus.in_valid = 1'b0;
        wait_done(lat, ok);
        check("post-reset latency", lat, 9);
        check("post-reset in_ready low while pending", ok, 1);
        @(posedge clk);
        #1;

        // Exhaustive sweep with random backpressure against an arithmetic model.
        rdy_mode = 2;
        for (int xv = 0; xv < 256; xv++) begin
            for (int yv = 0; yv < 16; yv++) begin
                if (yv == 0) send(xv, yv, 255, xv % 16, 1);
                else         send(xv, yv, xv / yv, xv % yv, 0);
            end
        end
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
